// File: rtl/mru_snapshot_serializer.sv
// Captures the 4-entry MRU list on request and streams its valid entries, newest first,
// over a valid/ready port. Requests arriving while a stream is in progress are counted as drops.
module mru_snapshot_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic              in_valid_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic              in_valid_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_3,
  input  logic              snap_req_in,
  input  logic              out_ready_in,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              out_valid,
  output logic              busy_out,
  output logic              empty_snap_out,
  output logic [CNT_W-1:0]  drop_cnt_out
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] snap_data [4];
  logic [3:0]        snap_vld;
  logic [DATA_W-1:0] in_data [4];
  logic [3:0]        in_vld;

  logic [DATA_W-1:0] out_data_n;
  logic [1:0]        out_idx_n;
  logic              out_last_n;
  logic              out_valid_n;
  logic              empty_n;
  logic              xfer, final_xfer, accept, drop;
  logic [3:0]        rem;
  logic [1:0]        sel;

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] r;
    r = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (m[i-1]) r = 2'(i - 1);
    end
    return r;
  endfunction

  function automatic logic [3:0] above(input logic [1:0] i);
    logic [3:0] base;
    base = 4'hE;
    return base << i;
  endfunction

  assign in_data[0] = in_0;
  assign in_data[1] = in_1;
  assign in_data[2] = in_2;
  assign in_data[3] = in_3;
  assign in_vld     = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  assign xfer       = out_valid & out_ready_in;
  assign final_xfer = xfer & out_last;
  assign accept     = snap_req_in & ((state == IDLE) | final_xfer);
  assign drop       = snap_req_in & (state == SEND) & ~final_xfer;
  assign busy_out   = (state == SEND);

  // The next beat is fully resolved here so every output comes straight from a flop;
  // a fresh capture presents its first beat from the input bus, later beats from the snapshot.
  always_comb begin
    state_n     = state;
    out_data_n  = out_data;
    out_idx_n   = out_idx;
    out_last_n  = out_last;
    out_valid_n = out_valid;
    empty_n     = 1'b0;
    rem         = '0;
    sel         = '0;
    if (accept) begin
      sel         = low_idx(in_vld);
      out_data_n  = in_data[sel];
      out_idx_n   = sel;
      out_last_n  = ~|(in_vld & above(sel));
      out_valid_n = |in_vld;
      empty_n     = ~|in_vld;
      state_n     = (|in_vld) ? SEND : IDLE;
    end else if (final_xfer) begin
      state_n     = IDLE;
      out_valid_n = 1'b0;
      out_last_n  = 1'b0;
    end else if (xfer) begin
      rem        = snap_vld & above(out_idx);
      sel        = low_idx(rem);
      out_data_n = snap_data[sel];
      out_idx_n  = sel;
      out_last_n = ~|(rem & above(sel));
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state          <= IDLE;
      snap_vld       <= '0;
      for (int unsigned i = 0; i < 4; i++) snap_data[i] <= '0;
      out_data       <= '0;
      out_idx        <= '0;
      out_last       <= 1'b0;
      out_valid      <= 1'b0;
      empty_snap_out <= 1'b0;
      drop_cnt_out   <= '0;
    end else begin
      state          <= state_n;
      out_data       <= out_data_n;
      out_idx        <= out_idx_n;
      out_last       <= out_last_n;
      out_valid      <= out_valid_n;
      empty_snap_out <= empty_n;
      if (accept) begin
        snap_data <= in_data;
        snap_vld  <= in_vld;
      end
      if (drop && (drop_cnt_out != '1)) drop_cnt_out <= drop_cnt_out + 1'b1;
    end
  end

endmodule

// File: doc/mru_snapshot_serializer.md
Name: mru_snapshot_serializer

Overview:
- Downstream consumer of the 4-entry most-recently-used data list (entries out_0..out_3 with per-entry valids, entry 0 newest).
- On a snapshot request it captures the whole list in one cycle.
- It then streams only the valid entries, newest first, over a valid/ready interface toward a readout or host-interface stage.
- Requests arriving while a stream is in progress are dropped and counted.

Parameters:
- DATA_W, 8, entry data width; must match the upstream list.
- CNT_W, 8, width of the dropped-request counter.

Ports:
- clk_in  input  1  clock, all state on rising edge
- reset_in  input  1  asynchronous active-low reset
- in_0  input  DATA_W  list entry 0 (newest)
- in_valid_0  input  1  entry 0 valid
- in_1 / in_valid_1  input  DATA_W / 1  entry 1 and its valid
- in_2 / in_valid_2  input  DATA_W / 1  entry 2 and its valid
- in_3 / in_valid_3  input  DATA_W / 1  entry 3 (oldest) and its valid
- snap_req_in  input  1  capture-and-stream request, sampled every cycle
- out_ready_in  input  1  downstream ready
- out_data  output  DATA_W  streamed entry data
- out_idx  output  2  list position of the streamed entry (0..3)
- out_last  output  1  beat is the last valid entry of the snapshot
- out_valid  output  1  beat valid
- busy_out  output  1  stream in progress
- empty_snap_out  output  1  one-cycle pulse: accepted snapshot had no valid entries
- drop_cnt_out  output  CNT_W  saturating count of dropped requests

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_in=0, takes effect immediately, not on a clock edge): state IDLE; all outputs 0; snapshot registers and valids cleared; drop_cnt_out=0.
- Reset asserted mid-stream aborts the stream. out_valid falls without a clock edge, and the partial stream is not resumed.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, SEND.
- IDLE:
  - busy_out=0, out_valid=0.
  - On snap_req_in=1, capture in_0..in_3 and in_valid_0..3 into snapshot registers at that edge.
  - If any captured valid is 1: go to SEND. out_valid=1 from the next cycle, presenting the lowest valid index. Latency is 1 cycle from request to first beat.
  - If no captured valid is 1: stay IDLE and assert empty_snap_out for exactly the following cycle.
- SEND:
  - busy_out=1.
  - A transfer occurs on any cycle with out_valid=1 and out_ready_in=1.
  - On a transfer, advance to the next-higher valid snapshot index, skipping invalid entries. There are no bubbles between beats when out_ready_in stays high.
  - While out_valid=1 and out_ready_in=0, out_data, out_idx and out_last are held stable.
  - out_last=1 only on the highest valid index of the snapshot.
  - A transfer with out_last=1 returns the FSM to IDLE. out_valid=0 and busy_out=0 the next cycle, unless a back-to-back request was accepted.
- Snapshot isolation: changes on in_*/in_valid_* after capture do not affect the stream in progress.
- Simultaneous events:
  - snap_req_in=1 in the same cycle as the final (out_last) transfer is accepted: a new capture happens at that edge.
  - If the new snapshot has valid entries, the next cycle shows out_valid=1 with the new snapshot's first beat, and busy_out stays 1.
  - If it has none, the next cycle has out_valid=0, busy_out=0 and empty_snap_out=1.
- Dropped requests: snap_req_in=1 in SEND, other than on a final-transfer cycle, is dropped.
  - drop_cnt_out increments by 1 and saturates at 2^CNT_W-1; it never wraps.
  - It is cleared only by reset.
- snap_req_in held high is treated as one request per cycle: accepted when acceptance is possible, otherwise counted as dropped.

Test Plan:
- Snapshot all four valid, in_0..3=0x11,0x22,0x33,0x44, ready=1, pulse snap_req -> beats on 4 consecutive cycles starting the cycle after the request: (0x11,idx0), (0x22,idx1), (0x33,idx2), (0x44,idx3,last=1). busy_out high 4 cycles, then 0.
- Valids {0,1,0,1}, in_1=0xAA, in_3=0xCC, ready=1 -> exactly two beats: (0xAA,idx1,last=0), then (0xCC,idx3,last=1).
- All valid, ready=0 for 3 cycles after first beat, inputs changed to 0xFF meanwhile -> out_data=0x11, idx0 held 3 cycles, then stream continues 0x22, 0x33, 0x44 unchanged; drop_cnt_out=0.
- snap_req pulsed during beat 2 -> drop_cnt_out=1. snap_req on the out_last transfer cycle with in_0=0x55 valid, others invalid -> next cycle (0x55,idx0,last=1), busy_out stays 1.
- Snapshot with all valids 0 -> empty_snap_out=1 for one cycle; out_valid and busy_out stay 0. Separately, snap_req held high through a long stream with CNT_W=2 -> drop_cnt_out saturates at 3.
- Assert reset_in=0 mid-stream between clock edges -> out_valid, busy_out and drop_cnt_out read 0 immediately. After release with no request, out_valid stays 0.
